mips32_prog_loader: RTL and testbench

MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

---
 rtl/mips32_prog_loader.sv | 118 +++++++++++
 tb/tb_mips32_prog_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - streams a header/payload/checksum image into instruction memory, then releases the core
module mips32_prog_loader #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    output logic          s_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_halt,
    output logic [31:0]   cpu_pc,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] DEPTH = 17'(1) << AW;

    state_t      state;
    logic [15:0] base_r;
    logic [15:0] count_r;
    logic [15:0] word_cnt;
    logic [31:0] csum;
    logic [16:0] hdr_end;
    logic        hdr_bad;
    logic [15:0] wr_addr;

    // Header covers [base, base+count); the image must fit without wrapping.
    assign hdr_end = {1'b0, s_data[31:16]} + {1'b0, s_data[15:0]};
    assign hdr_bad = (s_data[15:0] == 16'd0) || ({1'b0, s_data[31:16]} >= DEPTH) || (hdr_end > DEPTH);
    assign wr_addr = base_r + word_cnt;

    // Packed as {s_ready, busy, done, err, cpu_halt} for the state being entered.
    function automatic logic [4:0] status(input state_t s);
        case (s)
            HDR, DATA, CSUM: status = 5'b11001;
            DONE:            status = 5'b00100;
            ERR:             status = 5'b00011;
            default:         status = 5'b00001;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            {s_ready, busy, done, err, cpu_halt} <= 5'b00001;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_pc    <= '0;
            base_r    <= '0;
            count_r   <= '0;
            word_cnt  <= '0;
            csum      <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR;
                        {s_ready, busy, done, err, cpu_halt} <= status(HDR);
                        word_cnt <= '0;
                        csum     <= '0;
                    end
                end
                HDR: begin
                    if (s_valid) begin
                        if (hdr_bad) begin
                            state <= ERR;
                            {s_ready, busy, done, err, cpu_halt} <= status(ERR);
                        end else begin
                            state   <= DATA;
                            {s_ready, busy, done, err, cpu_halt} <= status(DATA);
                            base_r  <= s_data[31:16];
                            count_r <= s_data[15:0];
                            cpu_pc  <= {16'd0, s_data[31:16]};
                        end
                    end
                end
                DATA: begin
                    if (s_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr[AW-1:0];
                        mem_wdata <= s_data;
                        csum      <= csum ^ s_data;
                        word_cnt  <= word_cnt + 16'd1;
                        if (word_cnt == count_r - 16'd1) begin
                            state <= CSUM;
                            {s_ready, busy, done, err, cpu_halt} <= status(CSUM);
                        end
                    end
                end
                CSUM: begin
                    if (s_valid) begin
                        if (s_data == csum) begin
                            state <= DONE;
                            {s_ready, busy, done, err, cpu_halt} <= status(DONE);
                        end else begin
                            state <= ERR;
                            {s_ready, busy, done, err, cpu_halt} <= status(ERR);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    {s_ready, busy, done, err, cpu_halt} <= status(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb/tb_mips32_prog_loader.sv - randomized self-checking bench for mips32_prog_loader
module tb_mips32_prog_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_halt;
    logic [31:0]   cpu_pc;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [AW+31:0] obs_q[$];
    logic [31:0]    pay_q[$];

    mips32_prog_loader #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_halt(cpu_halt), .cpu_pc(cpu_pc), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && mem_we) obs_q.push_back({mem_addr, mem_wdata});
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input int gap);
        int n;
        n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL beat_accept: s_ready=%0b after 50 cycles, required 1 (word %h)", s_ready, d);
        end else begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({s_ready, mem_we, busy, done, err, cpu_halt} !== 6'b000001 || mem_addr !== '0 ||
            mem_wdata !== 32'd0 || cpu_pc !== 32'd0) begin
            errors++;
            $display("FAIL %s: got ready=%b we=%b busy=%b done=%b err=%b halt=%b addr=%0d wdata=%h pc=%h, required 0 0 0 0 0 1 0 0 0",
                     name, s_ready, mem_we, busy, done, err, cpu_halt, mem_addr, mem_wdata, cpu_pc);
        end
    endtask

    // Reference: a header either fits in memory or fails; a fitting image writes every payload
    // word at base+k and succeeds only when the trailing word equals the XOR of the payload.
    task automatic run_load(input string name, input logic [31:0] hdr, input logic [31:0] cs,
                            input int min_gap, input int max_gap, input bit start_mid);
        int             base;
        int             cnt;
        bit             bad;
        bit             good;
        logic [31:0]    x;
        logic [AW+31:0] exp_q[$];
        logic [AW-1:0]  ea;
        base = int'(hdr[31:16]);
        cnt  = int'(hdr[15:0]);
        bad  = (cnt == 0) || (base + cnt > DEPTH);
        x    = 32'd0;
        obs_q.delete();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || cpu_halt !== 1'b1) begin
            errors++;
            $display("FAIL %s start: busy=%b ready=%b halt=%b, required 1 1 1", name, busy, s_ready, cpu_halt);
        end
        send_beat(hdr, $urandom_range(min_gap, max_gap));
        if (!bad) begin
            for (int k = 0; k < cnt; k++) begin
                send_beat(pay_q[k], $urandom_range(min_gap, max_gap));
                x  = x ^ pay_q[k];
                ea = AW'(base + k);
                exp_q.push_back({ea, pay_q[k]});
                if (start_mid && k == 0) pulse_start();
            end
            send_beat(cs, $urandom_range(min_gap, max_gap));
        end
        good = !bad && (cs == x);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d, required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s write[%0d]: got addr=%0d data=%h, required addr=%0d data=%h", name, i,
                         obs_q[i][AW+31:32], obs_q[i][31:0], exp_q[i][AW+31:32], exp_q[i][31:0]);
            end
        end
        checks++;
        if (done !== good || err !== !good || cpu_halt !== !good || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s status: got done=%b err=%b halt=%b busy=%b ready=%b, required %b %b %b 0 0",
                     name, done, err, cpu_halt, busy, s_ready, good, !good, !good);
        end
        if (good) begin
            checks++;
            if (cpu_pc !== 32'(base)) begin
                errors++;
                $display("FAIL %s cpu_pc: got %h, required %h", name, cpu_pc, 32'(base));
            end
        end
    endtask

    task automatic load_basic_payload();
        pay_q.delete();
        pay_q.push_back(32'h00222000);
        pay_q.push_back(32'h04432800);
        pay_q.push_back(32'h10E60001);
    endtask

    task automatic test_reset();
        repeat (2) begin @(posedge clk); #1; end
        check_reset_values("reset_values");
        rst_n   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h00000003;
        repeat (3) begin @(posedge clk); #1; end
        s_valid = 1'b0;
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_basic();
        load_basic_payload();
        run_load("basic", 32'h00000003, 32'h14870801, 0, 0, 1'b0);
    endtask

    task automatic test_gapped();
        pay_q.delete();
        pay_q.push_back(32'h01AE6000);
        run_load("gapped", 32'h002F0001, 32'h01AE6000, 3, 3, 1'b0);
    endtask

    task automatic test_bad_csum();
        load_basic_payload();
        run_load("bad_csum", 32'h00000003, 32'h00000000, 0, 1, 1'b0);
    endtask

    task automatic test_bad_header();
        pay_q.delete();
        run_load("hdr_zero_count", 32'h00000000, 32'h0, 0, 0, 1'b0);
        run_load("hdr_overflow", 32'h03FF0002, 32'h0, 0, 0, 1'b0);
        run_load("hdr_base_high", 32'h04000001, 32'h0, 0, 0, 1'b0);
        pay_q.push_back(32'hDEADBEEF);
        pay_q.push_back(32'h12345678);
        run_load("hdr_exact_fit", 32'h03FE0002, 32'hDEADBEEF ^ 32'h12345678, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_basic_payload();
        obs_q.delete();
        pulse_start();
        send_beat(32'h00000003, 0);
        send_beat(pay_q[0], 0);
        send_beat(pay_q[1], 0);
        @(negedge clk); #1;
        s_valid = 1'b1;
        s_data  = pay_q[2];
        rst_n   = 1'b0;
        #1;
        check_reset_values("reset_mid_outputs");
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        s_valid = 1'b0;
        check_reset_values("reset_mid_idle");
        checks++;
        if (obs_q.size() !== 2) begin
            errors++;
            $display("FAIL reset_mid_writes: got %0d writes, required 2", obs_q.size());
        end
        run_load("after_reset", 32'h00000003, 32'h14870801, 0, 0, 1'b0);
    endtask

    task automatic test_start_ignored_and_restart();
        load_basic_payload();
        run_load("start_mid", 32'h00000003, 32'h14870801, 0, 1, 1'b1);
        pulse_start();
        checks++;
        if (cpu_halt !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_done: got halt=%b busy=%b ready=%b done=%b, required 1 1 1 0",
                     cpu_halt, busy, s_ready, done);
        end
        send_beat(32'h00000000, 0);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL restart_hdr_err: got err=%b, required 1", err);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int          cnt;
            int          base;
            int          mode;
            logic [31:0] x;
            logic [31:0] cs;
            cnt  = $urandom_range(1, 6);
            mode = $urandom_range(0, 9);
            case (mode)
                0: begin base = $urandom_range(0, DEPTH - 1); cnt = 0; end
                1: base = DEPTH - cnt + 1;
                2: base = $urandom_range(DEPTH, 65535);
                3: base = DEPTH - cnt;
                default: base = $urandom_range(0, DEPTH - cnt);
            endcase
            pay_q.delete();
            x = 32'd0;
            for (int k = 0; k < cnt; k++) begin
                pay_q.push_back($urandom);
                x = x ^ pay_q[k];
            end
            cs = ($urandom_range(0, 3) == 0) ? (x ^ ($urandom | 32'd1)) : x;
            run_load($sformatf("random%0d", it), {16'(base), 16'(cnt)}, cs, 0, 2, 1'b0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'd0;
        test_reset();
        test_basic();
        test_gapped();
        test_bad_csum();
        test_bad_header();
        test_reset_mid();
        test_start_ignored_and_restart();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
